// File: rtl/conv3x3_window_gen_if.sv
// conv3x3_window_gen_if: FIFO read port and window output handshake of the
// 3x3 window generator, bundled as one interface.
//   fifo_rd_en   - FIFO read strobe (generator -> FIFO)
//   fifo_rd_data - FIFO read data, valid one cycle after fifo_rd_en
//   fifo_empty   - FIFO empty flag
//   win_data     - 3x3 window, slice k*DATA_WIDTH holds p[k/3][k%3]
//   win_valid    - win_data valid
//   win_ready    - consumer accepts the window
// master = window generator side, slave = FIFO/consumer side.
interface conv3x3_window_gen_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    fifo_rd_en;
  logic [DATA_WIDTH-1:0]   fifo_rd_data;
  logic                    fifo_empty;
  logic [9*DATA_WIDTH-1:0] win_data;
  logic                    win_valid;
  logic                    win_ready;

  modport master (
    output fifo_rd_en, win_data, win_valid,
    input  fifo_rd_data, fifo_empty, win_ready
  );

  modport slave (
    input  fifo_rd_en, win_data, win_valid,
    output fifo_rd_data, fifo_empty, win_ready
  );
endinterface

// File: rtl/conv3x3_window_gen.sv
// conv3x3_window_gen: pops a raster-order frame from the line FIFO, keeps two
// row line buffers plus a 3x3 shift window and emits one window per valid
// (unpadded) output position over a valid/ready handshake.
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - begins a frame (honoured only when idle)
//   bus         - FIFO read port + window handshake (master side)
//   busy        - high whenever a frame is in progress
//   frame_done  - one-cycle pulse when the frame has fully drained
module conv3x3_window_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  conv3x3_window_gen_if.master bus,
  output logic                busy,
  output logic                frame_done
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int NW   = $clog2(NPIX + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [NW-1:0] NPIX_V   = NW'(NPIX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [NW-1:0]                     rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]                     col_q, col_d;
  logic [RW-1:0]                     row_q, row_d;
  logic [1:0]                        occ_q, occ_d;
  logic                              inflight_q, inflight_d;
  logic [1:0][DATA_WIDTH-1:0]        skid_q, skid_d;
  logic [2:0][2:0][DATA_WIDTH-1:0]   win_q, win_d;
  logic                              win_valid_q, win_valid_d;

  // Line buffers: lb0 holds the previous row, lb1 the row before that.
  // Not reset; the row counter keeps stale contents out of emitted windows.
  logic [DATA_WIDTH-1:0] lb0_mem [IMG_W];
  logic [DATA_WIDTH-1:0] lb1_mem [IMG_W];

  logic                  pop, rd_en, wr_idx;
  logic [2:0]            lvl;
  logic [DATA_WIDTH-1:0] pixel;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    skid_d      = skid_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    pixel       = skid_q[0];

    pop = (state_q == S_RUN) && (occ_q != 2'd0) && (!win_valid_q || bus.win_ready);
    // Skid level once this cycle's pop and the returning read settle; a new
    // read is only issued if its data is guaranteed a slot.
    lvl   = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    rd_en = (state_q == S_RUN) && !bus.fifo_empty && (lvl < 3'd2) && (rd_cnt_q < NPIX_V);
    inflight_d = rd_en;
    if (rd_en) rd_cnt_d = rd_cnt_q + 1'b1;

    // Skid buffer: head at index 0; returning data lands after the survivors.
    occ_d  = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    wr_idx = pop ? occ_q[1] : occ_q[0];
    if (pop) skid_d[0] = skid_q[1];
    if (inflight_q) skid_d[wr_idx] = bus.fifo_rd_data;

    if (bus.win_ready) win_valid_d = 1'b0;

    if (pop) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
        // Row start: drop previous-row columns so no window spans two rows.
        if (col_q == '0) begin
          win_d[r][0] = '0;
          win_d[r][1] = '0;
        end
      end
      win_d[0][2] = lb1_mem[col_q];
      win_d[1][2] = lb0_mem[col_q];
      win_d[2][2] = pixel;
      if (row_q >= RW'(2) && col_q >= CW'(2)) win_valid_d = 1'b1;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_RUN;
        rd_cnt_d = '0;
        col_d    = '0;
        row_d    = '0;
      end
      S_RUN:   if (pop && row_q == ROW_LAST && col_q == COL_LAST) state_d = S_FLUSH;
      S_FLUSH: if (!win_valid_q || bus.win_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      skid_q      <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      skid_q      <= skid_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      lb0_mem[col_q] <= pixel;
      lb1_mem[col_q] <= lb0_mem[col_q];
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_data   = win_q;
  assign busy           = (state_q != S_IDLE);
  assign frame_done     = (state_q == S_DONE);
endmodule

// File: doc/conv3x3_window_gen.md
Name: conv3x3_window_gen

Overview:
- Downstream consumer of the 16-bit line FIFO. Pops pixels in raster order and keeps two row line buffers plus a 3x3 shift window.
- Emits one 3x3 neighbourhood per valid output position, no padding, to the conv3x3 MAC array over a valid/ready handshake.
- One frame per start pulse; frame_done is pulsed when the frame completes.

Parameters:
- DATA_WIDTH, 16, pixel width; matches the FIFO data width.
- IMG_W, 32, pixels per row; legal range 3..1024.
- IMG_H, 32, rows per frame; legal range 3..1024.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data; valid one cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe.
- win_data  out  9*DATA_WIDTH  window; slice k*DATA_WIDTH holds p[r][c] with k=3r+c; p00 is top-left (oldest row, oldest column), p22 is the newest pixel.
- win_valid  out  1  win_data valid.
- win_ready  in  1  consumer accepts; a transfer occurs when win_valid && win_ready.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters, skid buffer and window registers cleared. Line-buffer RAM contents are not reset; the row counter gates their use.
- States: IDLE -> RUN on start; RUN -> FLUSH when the last pixel (row IMG_H-1, col IMG_W-1) is consumed; FLUSH -> DONE when no window is pending; DONE -> IDLE after 1 cycle, with frame_done=1 in DONE.
- fifo_rd_en = (state==RUN) && !fifo_empty && (occ - pop + inflight < 2) && (reads issued < IMG_W*IMG_H).
  - occ: 2-entry skid occupancy.
  - pop: skid head consumed this cycle.
  - inflight: a read was issued last cycle.
  - fifo_rd_en must never assert while fifo_empty=1.
- Capture: fifo_rd_data is written to the skid buffer in the cycle after fifo_rd_en.
- Consume: pop = occ>0 && (!win_valid || win_ready).
- On pop:
  - Window columns shift left.
  - New column = {linebuf1[col], linebuf0[col], pixel}.
  - linebuf1[col] <= linebuf0[col]; linebuf0[col] <= pixel.
  - col increments; on wrap col goes to 0 and row increments.
- win_valid is set in the cycle after a pop whose pixel had row>=2 && col>=2. It holds with stable win_data until accepted, then clears unless a new window is produced that same cycle.
- Column shift resets at each row start, so a window never mixes pixels from two rows.
- Latency: fifo_rd_en to the corresponding win_valid is 3 cycles.
- Throughput: with the FIFO non-empty and win_ready=1, sustains 1 pixel/cycle and 1 window/cycle for col>=2.
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- win_ready=0: pops stall; at most 2 pixels are buffered; no data is dropped or duplicated.
- fifo_empty mid-row: the pipeline idles and resumes with no gap artefacts.
- start outside IDLE: ignored.
- rst_n asserted mid-frame: immediate return to the reset state. The next frame needs a new start and the FIFO must be refilled by the producer.

Test Plan:
- 4x4 frame, pixels 0..15 preloaded, win_ready=1 -> 4 windows.
  - First window p00..p22 = 0,1,2,4,5,6,8,9,10.
  - Last window = 5,6,7,9,10,11,13,14,15.
  - frame_done pulses once, 1 cycle after FLUSH ends.
- Same frame with win_ready toggling 1-0-1-0 -> identical 4 windows in order; fifo_rd_en never asserts when the skid would overflow.
- FIFO fed 1 pixel every 3 cycles, 5x4 frame -> 6 windows matching the golden model; no fifo_rd_en while fifo_empty=1.
- Back-to-back 32x32 frame with continuous data and win_ready=1 -> 900 windows; win_valid high on consecutive cycles within each row for col 2..31.
- rst_n pulsed low after 7 pixels of a 4x4 frame, then start on a fresh frame -> outputs 0 during reset; new frame windows correct with no stale line-buffer data.
- start re-pulsed during RUN -> ignored; window count unchanged and busy stays high until DONE.
